// File: rtl/ysyx_24120013_pkg.sv
// Shared state encodings for the sequencing controller and its debug/trace consumers.
package ysyx_24120013_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ysyx_24120013_wait_timer.sv
// Consecutive-wait cycle counter; expired rises on the LIMIT-th running cycle after a clear.
module ysyx_24120013_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign expired = run && !clear && (count_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/ysyx_24120013_seq_ctrl.sv
// Multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional memory-wait timeout enabled by defining YSYX_24120013_SEQ_TIMEOUT_EN.
module ysyx_24120013_seq_ctrl
  import ysyx_24120013_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_rvalid,
  input  logic                 dec_is_mem,
  input  logic                 dec_is_ebreak,
  output logic                 dmem_req,
  input  logic                 dmem_ack,
  output logic                 ir_we,
  output logic                 rf_wen,
  output logic                 pc_we,
  output logic                 halt,
  output logic                 timeout_err,
  output logic [STATE_W-1:0]   state,
  output logic [CNT_WIDTH-1:0] instret
);

  seq_state_e           state_q, state_d;
  logic                 mem_flag_q, mem_flag_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 tmo_expired;
  logic                 wait_run;

  // Waiting means sitting in a wait state with no response this cycle.
  assign wait_run = ((state_q == ST_FETCH) && !imem_rvalid) ||
                    ((state_q == ST_MEM)   && !dmem_ack);

`ifdef YSYX_24120013_SEQ_TIMEOUT_EN
  logic timeout_err_q;

  ysyx_24120013_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .clear  (rst || !is_wait_state(state_q)),
    .run    (wait_run),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (tmo_expired) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = wait_run ^ (TIMEOUT_CYCLES == 0);
  assign tmo_expired        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_flag_d = mem_flag_q;
    instret_d  = instret_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_rvalid) begin
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        mem_flag_d = dec_is_mem;
        state_d    = dec_is_ebreak ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: state_d = mem_flag_q ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (tmo_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        instret_d = instret_q + CNT_WIDTH'(1);
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_flag_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_flag_q <= mem_flag_d;
      instret_q  <= instret_d;
    end
  end

  // ir_we is the only Mealy strobe; everything else decodes from state alone.
  assign imem_req = (state_q == ST_FETCH);
  assign ir_we    = (state_q == ST_FETCH) && imem_rvalid;
  assign dmem_req = (state_q == ST_MEM);
  assign rf_wen   = (state_q == ST_WB);
  assign pc_we    = (state_q == ST_WB);
  assign halt     = (state_q == ST_HALT);
  assign state    = state_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_ysyx_24120013_seq_ctrl.sv
// Directed self-checking bench for ysyx_24120013_seq_ctrl (4-bit instret, TIMEOUT_CYCLES=4).
module tb_ysyx_24120013_seq_ctrl;

  localparam int TimeoutCycles = 4;
  localparam int CntWidth      = 4;

  localparam logic [2:0] SIdle   = 3'd0;
  localparam logic [2:0] SFetch  = 3'd1;
  localparam logic [2:0] SDecode = 3'd2;
  localparam logic [2:0] SExec   = 3'd3;
  localparam logic [2:0] SMem    = 3'd4;
  localparam logic [2:0] SWb     = 3'd5;
  localparam logic [2:0] SHalt   = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imemRvalid = 1'b0;
  logic decIsMem = 1'b0;
  logic decIsEbreak = 1'b0;
  logic dmemAck = 1'b0;

  logic                imemReq, dmemReq, irWe, rfWen, pcWe, haltO, timeoutErr;
  logic [2:0]          stateO;
  logic [CntWidth-1:0] instretO;

  int checkCount = 0;
  int errorCount = 0;

  logic [2:0] plainSeq [4] = '{SFetch, SDecode, SExec, SWb};

  ysyx_24120013_seq_ctrl #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .CNT_WIDTH     (CntWidth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imemReq),
    .imem_rvalid  (imemRvalid),
    .dec_is_mem   (decIsMem),
    .dec_is_ebreak(decIsEbreak),
    .dmem_req     (dmemReq),
    .dmem_ack     (dmemAck),
    .ir_we        (irWe),
    .rf_wen       (rfWen),
    .pc_we        (pcWe),
    .halt         (haltO),
    .timeout_err  (timeoutErr),
    .state        (stateO),
    .instret      (instretO)
  );

  always #5 clk = ~clk;

  // Leaves the bench at a falling edge with the DUT freshly in FETCH.
  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    imemRvalid = 1'b0; decIsMem = 1'b0; decIsEbreak = 1'b0; dmemAck = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_plain;
    for (int k = 0; k < 4; k++) begin
      imemRvalid = (k == 0);
      @(negedge clk);
    end
    imemRvalid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; imemRvalid = 1'b1; dmemAck = 1'b1; decIsMem = 1'b1; decIsEbreak = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkCount++;
    if (stateO !== SIdle) begin
      errorCount++; $display("[TB] FAIL reset_state: got %0d expected %0d", stateO, SIdle);
    end
    checkCount++;
    if ({imemReq, dmemReq, irWe, rfWen, pcWe, haltO, timeoutErr} !== 7'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000",
               {imemReq, dmemReq, irWe, rfWen, pcWe, haltO, timeoutErr});
    end
    checkCount++;
    if (instretO !== 4'd0) begin
      errorCount++; $display("[TB] FAIL reset_instret: got %0d expected 0", instretO);
    end
    rst = 1'b0; imemRvalid = 1'b0; dmemAck = 1'b0; decIsMem = 1'b0; decIsEbreak = 1'b0;
    @(negedge clk);
    #1;
    checkCount++;
    if (stateO !== SFetch || imemReq !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL idle_to_fetch: got state=%0d imem_req=%b expected state=1 imem_req=1",
               stateO, imemReq);
    end
  endtask

  task automatic test_plain_instr;
    apply_reset();
    imemRvalid = 1'b1;
    #1;
    checkCount++;
    if (irWe !== 1'b1 || imemReq !== 1'b1) begin
      errorCount++; $display("[TB] FAIL fetch_ir_we: got ir_we=%b imem_req=%b expected 1 1", irWe, imemReq);
    end
    @(negedge clk);
    imemRvalid = 1'b0;
    #1;
    checkCount++;
    if (stateO !== SDecode || irWe !== 1'b0 || imemReq !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL decode_cycle: got state=%0d ir_we=%b imem_req=%b expected 2 0 0", stateO, irWe, imemReq);
    end
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SExec || rfWen !== 1'b0) begin
      errorCount++; $display("[TB] FAIL exec_cycle: got state=%0d rf_wen=%b expected 3 0", stateO, rfWen);
    end
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SWb || rfWen !== 1'b1 || pcWe !== 1'b1 || instretO !== 4'd0) begin
      errorCount++;
      $display("[TB] FAIL wb_strobes: got state=%0d rf_wen=%b pc_we=%b instret=%0d expected 5 1 1 0",
               stateO, rfWen, pcWe, instretO);
    end
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SFetch || rfWen !== 1'b0 || instretO !== 4'd1) begin
      errorCount++;
      $display("[TB] FAIL first_retire: got state=%0d rf_wen=%b instret=%0d expected 1 0 1", stateO, rfWen, instretO);
    end
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 4; k++) begin
        imemRvalid = (k == 0);
        #1;
        checkCount++;
        if (stateO !== plainSeq[k]) begin
          errorCount++;
          $display("[TB] FAIL plain_seq[%0d][%0d]: got %0d expected %0d", i, k, stateO, plainSeq[k]);
        end
        @(negedge clk);
      end
    end
    imemRvalid = 1'b0;
    #1;
    checkCount++;
    if (instretO !== 4'd10 || stateO !== SFetch) begin
      errorCount++;
      $display("[TB] FAIL ten_instr: got instret=%0d state=%0d expected 10 1", instretO, stateO);
    end
  endtask

  task automatic test_mem_wait;
    logic [2:0] expState [9] = '{SFetch, SDecode, SExec, SMem, SMem, SMem, SMem, SWb, SFetch};
    int dmemReqCycles = 0;
    int overlap = 0;
    apply_reset();
    for (int n = 0; n < 9; n++) begin
      imemRvalid = (n == 0);
      decIsMem   = (n == 1);
      dmemAck    = (n == 6);
      #1;
      checkCount++;
      if (stateO !== expState[n]) begin
        errorCount++; $display("[TB] FAIL mem_seq[%0d]: got %0d expected %0d", n, stateO, expState[n]);
      end
      if (dmemReq === 1'b1) dmemReqCycles++;
      if (dmemReq === 1'b1 && imemReq === 1'b1) overlap++;
      @(negedge clk);
    end
    dmemAck = 1'b0;
    checkCount++;
    if (dmemReqCycles != 4) begin
      errorCount++; $display("[TB] FAIL dmem_req_cycles: got %0d expected 4", dmemReqCycles);
    end
    checkCount++;
    if (overlap != 0) begin
      errorCount++; $display("[TB] FAIL req_overlap: got %0d cycles expected 0", overlap);
    end
    #1;
    checkCount++;
    if (instretO !== 4'd1) begin
      errorCount++; $display("[TB] FAIL mem_retire: got instret=%0d expected 1", instretO);
    end
  endtask

  task automatic test_ebreak;
    apply_reset();
    run_plain();
    imemRvalid = 1'b1;
    @(negedge clk);
    imemRvalid = 1'b0; decIsEbreak = 1'b1; decIsMem = 1'b1;
    #1;
    checkCount++;
    if (stateO !== SDecode) begin
      errorCount++; $display("[TB] FAIL ebreak_decode: got %0d expected 2", stateO);
    end
    @(negedge clk);
    decIsEbreak = 1'b0; decIsMem = 1'b0; imemRvalid = 1'b1; dmemAck = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkCount++;
      if (stateO !== SHalt || haltO !== 1'b1 || instretO !== 4'd1 ||
          {imemReq, dmemReq, irWe, rfWen, pcWe} !== 5'b0) begin
        errorCount++;
        $display("[TB] FAIL halt_hold[%0d]: got state=%0d halt=%b instret=%0d strobes=%b expected 6 1 1 00000",
                 c, stateO, haltO, instretO, {imemReq, dmemReq, irWe, rfWen, pcWe});
      end
      @(negedge clk);
    end
    imemRvalid = 1'b0; dmemAck = 1'b0;
  endtask

  task automatic test_reset_mid_mem;
    apply_reset();
    run_plain();
    for (int n = 0; n < 5; n++) begin
      imemRvalid = (n == 0);
      decIsMem   = (n == 1);
      @(negedge clk);
    end
    #1;
    checkCount++;
    if (stateO !== SMem || dmemReq !== 1'b1 || instretO !== 4'd1) begin
      errorCount++;
      $display("[TB] FAIL mem_before_rst: got state=%0d dmem_req=%b instret=%0d expected 4 1 1", stateO, dmemReq, instretO);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SIdle || dmemReq !== 1'b0 || instretO !== 4'd0) begin
      errorCount++;
      $display("[TB] FAIL rst_mid_mem: got state=%0d dmem_req=%b instret=%0d expected 0 0 0", stateO, dmemReq, instretO);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SFetch) begin
      errorCount++; $display("[TB] FAIL refetch_after_rst: got %0d expected 1", stateO);
    end
  endtask

  task automatic test_timeout;
    apply_reset();
`ifdef YSYX_24120013_SEQ_TIMEOUT_EN
    repeat (TimeoutCycles - 1) @(negedge clk);
    #1;
    checkCount++;
    if (stateO !== SFetch || timeoutErr !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL timeout_early: got state=%0d timeout_err=%b expected 1 0", stateO, timeoutErr);
    end
    @(negedge clk); #1;
    checkCount++;
    if (stateO !== SHalt || timeoutErr !== 1'b1 || haltO !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL timeout_halt: got state=%0d timeout_err=%b halt=%b expected 6 1 1", stateO, timeoutErr, haltO);
    end
    apply_reset();
    #1;
    checkCount++;
    if (timeoutErr !== 1'b0) begin
      errorCount++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeoutErr);
    end
`else
    repeat (100) @(negedge clk);
    #1;
    checkCount++;
    if (stateO !== SFetch || imemReq !== 1'b1 || timeoutErr !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL no_timeout: got state=%0d imem_req=%b timeout_err=%b expected 1 1 0", stateO, imemReq, timeoutErr);
    end
`endif
  endtask

  task automatic test_spurious_ack_wrap;
    apply_reset();
    dmemAck = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checkCount++;
      if (stateO !== SFetch || dmemReq !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL spurious_ack[%0d]: got state=%0d dmem_req=%b expected 1 0", c, stateO, dmemReq);
      end
      @(negedge clk);
    end
    repeat (15) run_plain();
    #1;
    checkCount++;
    if (instretO !== 4'hF) begin
      errorCount++; $display("[TB] FAIL instret_all_ones: got %0d expected 15", instretO);
    end
    run_plain();
    #1;
    checkCount++;
    if (instretO !== 4'h0 || stateO !== SFetch) begin
      errorCount++;
      $display("[TB] FAIL instret_wrap: got instret=%0d state=%0d expected 0 1", instretO, stateO);
    end
    dmemAck = 1'b0;
  endtask

  initial begin
    $display("[TB] starting seq_ctrl bench");
    test_reset();
    test_plain_instr();
    test_mem_wait();
    test_ebreak();
    test_reset_mid_mem();
    test_timeout();
    test_spurious_ack_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
